// File: rtl/dot_marge_to_pixel_converter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : dot_marge_to_pixel_converter_pkg
// Description : RGBA4444 field layout, layer count and per-channel alpha blend
//               shared by the pixel converter and its storage.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package dot_marge_to_pixel_converter_pkg;

   localparam int DOT_W      = 16;
   localparam int CH_W       = 4;
   localparam int PIX_W      = 12;
   localparam int NUM_LAYERS = 10;

   localparam int A_MSB = 15;
   localparam int A_LSB = 12;
   localparam int R_MSB = 11;
   localparam int R_LSB = 8;
   localparam int G_MSB = 7;
   localparam int G_LSB = 4;
   localparam int B_MSB = 3;
   localparam int B_LSB = 0;

   // Alpha 4'hF is promoted to a weight of 16 so an opaque layer fully
   // replaces the destination instead of leaving a 1/16 residue.
   function automatic logic [CH_W-1:0] blend_channel(
      input logic [CH_W-1:0] src,
      input logic [CH_W-1:0] dst,
      input logic [CH_W-1:0] alpha
   );
      logic [4:0] w;
      logic [7:0] acc;
      w   = (alpha == 4'hF) ? 5'd16 : {1'b0, alpha};
      acc = ({4'd0, src} * {3'd0, w}) + ({4'd0, dst} * {3'd0, 5'd16 - w});
      return 4'(acc >> 4);
   endfunction

   // Blend one RGBA4444 dot over an RGB444 destination.
   function automatic logic [PIX_W-1:0] blend_pixel(
      input logic [DOT_W-1:0] dot,
      input logic [PIX_W-1:0] dst
   );
      logic [CH_W-1:0] a;
      a = dot[A_MSB:A_LSB];
      return {blend_channel(dot[R_MSB:R_LSB], dst[11:8], a),
              blend_channel(dot[G_MSB:G_LSB], dst[7:4],  a),
              blend_channel(dot[B_MSB:B_LSB], dst[3:0],  a)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dot_marge_to_pixel_converter_sync_pixel_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : sync_pixel_fifo
// Description : Single-clock FIFO with registered read data, a one-cycle read
//               valid strobe and an occupancy count output.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module sync_pixel_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_fire;
   logic             rd_fire;

   assign wr_fire = wr_en & (count != CNT_W'(DEPTH));
   assign rd_fire = rd_en & (count != '0);

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_fire) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         case ({wr_fire, rd_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/dot_marge_to_pixel_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : dot_marge_to_pixel_converter
// Description : Blends ten RGBA4444 layer dots back-to-front over black,
//               registers the RGB444 result and queues it in a pixel FIFO.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module dot_marge_to_pixel_converter
   import dot_marge_to_pixel_converter_pkg::*;
#(
   parameter int pColorDepth   = 16,
   parameter int pFifoDepth    = 16,
   parameter int pFifoBitWidth = pColorDepth - pColorDepth / 4
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic [pColorDepth-1:0]   iDistantground,
   input  logic [pColorDepth-1:0]   iBackground,
   input  logic [pColorDepth-1:0]   iField,
   input  logic [pColorDepth-1:0]   iNpc,
   input  logic [pColorDepth-1:0]   iPlayer,
   input  logic [pColorDepth-1:0]   iObject,
   input  logic [pColorDepth-1:0]   iEffect1,
   input  logic [pColorDepth-1:0]   iEffect2,
   input  logic [pColorDepth-1:0]   iForeground,
   input  logic [pColorDepth-1:0]   iMenuWindow,
   input  logic                     iEds,
   output logic                     oFull,
   output logic [pFifoBitWidth-1:0] oDd,
   output logic                     oVdd,
   input  logic                     iEdd,
   output logic                     oEmp
);

   localparam int CNT_W = $clog2(pFifoDepth) + 1;

   logic [DOT_W-1:0]         layers [NUM_LAYERS];
   logic [PIX_W-1:0]         blended;
   logic [pFifoBitWidth-1:0] blend_reg;
   logic                     blend_vld;
   logic [CNT_W-1:0]         fifo_count;

   // Layer list ordered back to front; index 0 is blended first.
   always_comb begin
      layers[0] = iDistantground;
      layers[1] = iBackground;
      layers[2] = iField;
      layers[3] = iNpc;
      layers[4] = iPlayer;
      layers[5] = iObject;
      layers[6] = iEffect1;
      layers[7] = iEffect2;
      layers[8] = iForeground;
      layers[9] = iMenuWindow;
   end

   // Combinational blend chain starting from a black destination.
   always_comb begin
      blended = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         blended = blend_pixel(layers[i], blended);
      end
   end

   // One-stage pipeline; strobes arriving while full never load it.
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         blend_reg <= '0;
         blend_vld <= 1'b0;
      end else begin
         blend_vld <= iEds & ~oFull;
         if (iEds & ~oFull) begin
            blend_reg <= blended;
         end
      end
   end

   // Full one entry early leaves room for the pixel already in the pipeline.
   assign oFull = (fifo_count >= CNT_W'(pFifoDepth - 1));
   assign oEmp  = (fifo_count == '0);

   sync_pixel_fifo #(
      .DEPTH (pFifoDepth),
      .WIDTH (pFifoBitWidth)
   ) u_fifo (
      .clk      (iClk),
      .rst_n    (iRst),
      .wr_en    (blend_vld),
      .wr_data  (blend_reg),
      .rd_en    (iEdd),
      .rd_data  (oDd),
      .rd_valid (oVdd),
      .count    (fifo_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_dot_marge_to_pixel_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_dot_marge_to_pixel_converter
// Description : Directed self-checking bench for the dot-to-pixel converter.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_dot_marge_to_pixel_converter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] dg, bg, fld, npc, ply, obj, ef1, ef2, fg, mw;
   logic        eds, edd;
   logic        full, vdd, emp;
   logic [11:0] dd;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dot_marge_to_pixel_converter dut (
      .iClk           (clk),
      .iRst           (rst),
      .iDistantground (dg),
      .iBackground    (bg),
      .iField         (fld),
      .iNpc           (npc),
      .iPlayer        (ply),
      .iObject        (obj),
      .iEffect1       (ef1),
      .iEffect2       (ef2),
      .iForeground    (fg),
      .iMenuWindow    (mw),
      .iEds           (eds),
      .oFull          (full),
      .oDd            (dd),
      .oVdd           (vdd),
      .iEdd           (edd),
      .oEmp           (emp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_layers();
      dg = '0; bg = '0; fld = '0; npc = '0; ply = '0;
      obj = '0; ef1 = '0; ef2 = '0; fg = '0; mw = '0;
   endtask

   // Issue one enqueue strobe with the current layer values.
   task automatic push_cur();
      eds = 1'b1;
      tick();
      eds = 1'b0;
   endtask

   // Enqueue an opaque background-only pixel.
   task automatic push_bg(input logic [11:0] rgb);
      clear_layers();
      bg = {4'hF, rgb};
      push_cur();
   endtask

   task automatic pop(input string tag, input logic [11:0] exp);
      edd = 1'b1;
      tick();
      edd = 1'b0;
      check({tag, "_vdd"}, {31'd0, vdd}, 32'd1);
      check(tag, {20'd0, dd}, {20'd0, exp});
   endtask

   initial begin
      rst = 1'b0; eds = 1'b0; edd = 1'b0;
      clear_layers();
      tick();
      tick();
      check("rst_emp",  {31'd0, emp},  32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_vdd",  {31'd0, vdd},  32'd0);
      check("rst_dd",   {20'd0, dd},   32'h000);
      rst = 1'b1;
      tick();

      // Opaque single layer, write latency of one cycle.
      clear_layers();
      bg = 16'hF0F0;
      push_cur();
      check("lat_emp_inflight", {31'd0, emp}, 32'd1);
      tick();
      check("lat_emp_written", {31'd0, emp}, 32'd0);
      pop("opaque", 12'h0F0);
      tick();
      check("hold_vdd", {31'd0, vdd}, 32'd0);
      check("hold_dd",  {20'd0, dd},  32'h0F0);
      check("drained_emp", {31'd0, emp}, 32'd1);
      edd = 1'b1;
      tick();
      edd = 1'b0;
      check("rd_empty_vdd", {31'd0, vdd}, 32'd0);
      check("rd_empty_dd",  {20'd0, dd},  32'h0F0);

      // Layer order and alpha weighting.
      clear_layers(); bg = 16'hFF00; mw  = 16'hF00F; push_cur();
      clear_layers(); bg = 16'hF0F0; ply = 16'h8F00; push_cur();
      clear_layers(); bg = 16'h8F00;                 push_cur();
      clear_layers(); bg = 16'hF0F0; obj = 16'h0FFF; push_cur();
      clear_layers();
      tick();
      pop("order_menu",   12'h00F);
      pop("alpha_half",   12'h770);
      pop("alpha_black",  12'h700);
      pop("transparent",  12'h0F0);
      check("order_emp", {31'd0, emp}, 32'd1);

      // Fill to the full threshold, then drain in order.
      for (int k = 0; k < 15; k++) begin
         push_bg(12'(12'h100 + k));
      end
      tick();
      check("fill_full", {31'd0, full}, 32'd1);
      push_bg(12'hABC);
      tick();
      check("fill_full_hold", {31'd0, full}, 32'd1);
      for (int k = 0; k < 15; k++) begin
         pop($sformatf("fill_rd%0d", k), 12'(12'h100 + k));
         if (k == 0) begin
            check("fill_full_clear", {31'd0, full}, 32'd0);
         end
      end
      check("fill_emp", {31'd0, emp}, 32'd1);

      // Concurrent enqueue and dequeue with five stored.
      for (int k = 0; k < 5; k++) begin
         push_bg(12'(12'h200 + k));
      end
      tick();
      clear_layers();
      bg = 16'hF205; eds = 1'b1; edd = 1'b1;
      tick();
      check("sim_vdd0", {31'd0, vdd}, 32'd1);
      check("sim_dd0",  {20'd0, dd},  32'h200);
      bg = 16'hF206;
      tick();
      check("sim_vdd1", {31'd0, vdd}, 32'd1);
      check("sim_dd1",  {20'd0, dd},  32'h201);
      eds = 1'b0; edd = 1'b0;
      tick();
      for (int k = 2; k < 7; k++) begin
         pop($sformatf("sim_rd%0d", k), 12'(12'h200 + k));
      end
      check("sim_emp", {31'd0, emp}, 32'd1);

      // Reset mid-operation with one pixel still in flight.
      for (int k = 0; k < 8; k++) begin
         push_bg(12'(12'h300 + k));
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("mid_rst_emp",  {31'd0, emp},  32'd1);
      check("mid_rst_vdd",  {31'd0, vdd},  32'd0);
      check("mid_rst_full", {31'd0, full}, 32'd0);
      check("mid_rst_dd",   {20'd0, dd},   32'h000);
      tick();
      check("mid_rst_inflight", {31'd0, emp}, 32'd1);
      edd = 1'b1;
      tick();
      edd = 1'b0;
      check("mid_rst_rd_vdd", {31'd0, vdd}, 32'd0);
      push_bg(12'h3AA);
      tick();
      pop("mid_rst_new", 12'h3AA);
      check("mid_rst_end_emp", {31'd0, emp}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
